// File: rtl/trace_pkg.sv
// Shared definitions for the instruction-trace capture unit: FSM encoding and
// packed entry layout. The layout grows by CYCLE_W when TRACE_TIMESTAMP_EN is defined.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  localparam int INST_W = 32;

  // Entry layout, LSB first: pc | instruction | alu result | write-back | stamp
  function automatic int off_pc(input int xlen);
    return 0;
  endfunction

  function automatic int off_inst(input int xlen);
    return xlen;
  endfunction

  function automatic int off_ula(input int xlen);
    return xlen + INST_W;
  endfunction

  function automatic int off_wb(input int xlen);
    return 2 * xlen + INST_W;
  endfunction

  function automatic int off_cyc(input int xlen);
    return 3 * xlen + INST_W;
  endfunction

  function automatic int entry_w(input int xlen, input int cycle_w);
`ifdef TRACE_TIMESTAMP_EN
    return off_cyc(xlen) + cycle_w;
`else
    return off_cyc(xlen) + 0 * cycle_w;
`endif
  endfunction

endpackage

// File: rtl/trace_mem.sv
// Trace buffer storage: DEPTH x WIDTH, one synchronous write port and one
// asynchronous read port.
module trace_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; contents are only ever read behind a valid
  // count, so a reset would cost a mux per bit and buy nothing.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trace_datapath.sv
// Instruction-trace capture: circular buffer armed by software, triggered on a
// PC match, streamed out oldest-first. TRACE_TIMESTAMP_EN adds per-entry cycle stamps.
module trace_datapath
  import trace_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int POST_CYCLES = 8,
  parameter int CYCLE_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valido,
  input  logic [XLEN-1:0]          pc_atual,
  input  logic [31:0]              instrucao,
  input  logic [XLEN-1:0]          resultado_ula,
  input  logic [XLEN-1:0]          dado_escrita,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [XLEN-1:0]          trig_pc,
  input  logic                     trig_forca,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [XLEN-1:0]          rd_pc,
  output logic [XLEN-1:0]          rd_ula,
  output logic [XLEN-1:0]          rd_wb,
  output logic [31:0]              rd_inst,
  output logic [CYCLE_W-1:0]       rd_ciclo,
  output logic [1:0]               estado,
  output logic [$clog2(DEPTH):0]   contagem
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (POST_CYCLES < 1) ? 1 : $clog2(POST_CYCLES + 1);
  localparam int EW = entry_w(XLEN, CYCLE_W);

  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [PW-1:0] POST_LOAD = PW'(POST_CYCLES);

  state_e         state_q;
  logic [AW-1:0]  wr_ptr_q;
  logic [CW-1:0]  cnt_q;
  logic [PW-1:0]  post_q;

  logic           trig_hit;
  logic           wr_en;
  logic           rd_fire;
  logic [CW-1:0]  cnt_sat_d;
  logic [AW-1:0]  rd_ptr;
  logic [EW-1:0]  wdata;
  logic [EW-1:0]  rdata;

  assign trig_hit  = valido && ((pc_atual == trig_pc) || trig_forca);
  assign wr_en     = valido && !abort && ((state_q == ST_ARMED) || (state_q == ST_POST));
  assign rd_valid  = (state_q == ST_READ) && (cnt_q != '0);
  assign rd_fire   = rd_valid && rd_ready;
  assign cnt_sat_d = (cnt_q == FULL) ? FULL : cnt_q + CW'(1);

  // Oldest entry sits contagem slots behind the write pointer; when full the
  // low bits of contagem are zero, which lands exactly on the overwrite slot.
  assign rd_ptr = wr_ptr_q - cnt_q[AW-1:0];

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      post_q   <= '0;
    end else if (abort) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      post_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_q  <= ST_ARMED;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
          end
        end
        ST_ARMED: begin
          if (valido) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            cnt_q    <= cnt_sat_d;
            if (trig_hit) begin
              if (POST_CYCLES == 0) begin
                state_q <= ST_READ;
              end else begin
                post_q  <= POST_LOAD;
                state_q <= ST_POST;
              end
            end
          end
        end
        ST_POST: begin
          if (valido) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            cnt_q    <= cnt_sat_d;
            post_q   <= post_q - PW'(1);
            if (post_q == PW'(1)) begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (rd_fire) begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [CYCLE_W-1:0] cyc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + CYCLE_W'(1);
    end
  end

  assign wdata    = {cyc_q, dado_escrita, resultado_ula, instrucao, pc_atual};
  assign rd_ciclo = rd_valid ? rdata[off_cyc(XLEN) +: CYCLE_W] : '0;
`else
  assign wdata    = {dado_escrita, resultado_ula, instrucao, pc_atual};
  assign rd_ciclo = '0;
`endif

  trace_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr),
    .rdata_o (rdata)
  );

  // Fields are forced to zero outside a valid readout so reset and idle show
  // zeros rather than stale buffer contents.
  assign rd_pc    = rd_valid ? rdata[off_pc(XLEN)   +: XLEN]   : '0;
  assign rd_inst  = rd_valid ? rdata[off_inst(XLEN) +: INST_W] : '0;
  assign rd_ula   = rd_valid ? rdata[off_ula(XLEN)  +: XLEN]   : '0;
  assign rd_wb    = rd_valid ? rdata[off_wb(XLEN)   +: XLEN]   : '0;

  assign estado   = state_q;
  assign contagem = cnt_q;

endmodule

// File: tb/tb_trace_datapath.sv
// Self-checking bench for trace_datapath: a scoreboard queue models the
// circular buffer and is compared entry-by-entry during readout.
module tb_trace_datapath;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 16;
  localparam int POST    = 4;
  localparam int CYCLE_W = 16;
  localparam int CNTW    = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               valido = 1'b0;
  logic [XLEN-1:0]    pc_atual = '0;
  logic [31:0]        instrucao = '0;
  logic [XLEN-1:0]    resultado_ula = '0;
  logic [XLEN-1:0]    dado_escrita = '0;
  logic               arm = 1'b0;
  logic               abort = 1'b0;
  logic [XLEN-1:0]    trig_pc = '0;
  logic               trig_forca = 1'b0;
  logic               rd_valid;
  logic               rd_ready = 1'b0;
  logic [XLEN-1:0]    rd_pc, rd_ula, rd_wb;
  logic [31:0]        rd_inst;
  logic [CYCLE_W-1:0] rd_ciclo;
  logic [1:0]         estado;
  logic [CNTW-1:0]    contagem;

  trace_datapath #(
    .XLEN(XLEN), .DEPTH(DEPTH), .POST_CYCLES(POST), .CYCLE_W(CYCLE_W)
  ) dut (
    .clk(clk), .reset(reset), .valido(valido), .pc_atual(pc_atual),
    .instrucao(instrucao), .resultado_ula(resultado_ula), .dado_escrita(dado_escrita),
    .arm(arm), .abort(abort), .trig_pc(trig_pc), .trig_forca(trig_forca),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_ula(rd_ula),
    .rd_wb(rd_wb), .rd_inst(rd_inst), .rd_ciclo(rd_ciclo), .estado(estado),
    .contagem(contagem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]        pc;
    logic [31:0]        inst;
    logic [31:0]        ula;
    logic [31:0]        wb;
    logic [CYCLE_W-1:0] cyc;
  } entry_t;

  entry_t sb[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc_m;

  // Reference free-running cycle counter
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc_m <= 0;
    else        cyc_m <= cyc_m + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic entry_t make_entry(input int i);
    entry_t e;
    e.pc   = 32'(i * 4);
    e.inst = 32'h0000_0013 + 32'(i << 7);
    e.ula  = 32'hA000_0000 | 32'(i);
    e.wb   = 32'h5A5A_0000 ^ 32'(i * 3);
`ifdef TRACE_TIMESTAMP_EN
    e.cyc  = CYCLE_W'(cyc_m);
`else
    e.cyc  = '0;
`endif
    return e;
  endfunction

  task automatic drive_instr(input int i);
    entry_t e;
    e = make_entry(i);
    valido        = 1'b1;
    pc_atual      = e.pc;
    instrucao     = e.inst;
    resultado_ula = e.ula;
    dado_escrita  = e.wb;
  endtask

  // Arm while also presenting a matching PC: only the arm may take effect.
  task automatic do_arm(input logic [31:0] tpc);
    @(negedge clk);
    trig_pc    = tpc;
    arm        = 1'b1;
    valido     = 1'b1;
    pc_atual   = tpc;
    trig_forca = 1'b1;
    @(negedge clk);
    arm        = 1'b0;
    valido     = 1'b0;
    trig_forca = 1'b0;
    check("arm_state", estado, 2'd1);
    check("arm_count", contagem, 0);
  endtask

  // Drives sequential instructions until the model says the post window closed.
  task automatic capture(input logic [31:0] tpc, input int gap_after, input int gap_len,
                         input int arm_at, input bit force_first);
    int     i = 0;
    int     rem = 0;
    int     post_done = 0;
    int     gaps_left = gap_len;
    bit     in_post = 1'b0;
    bit     done = 1'b0;
    entry_t e;
    trig_pc = tpc;
    while (!done && i < 200) begin
      if (in_post && post_done == gap_after && gaps_left > 0) begin
        valido = 1'b0;
        arm    = 1'b0;
        gaps_left--;
      end else begin
        e = make_entry(i);
        drive_instr(i);
        trig_forca = force_first && (i == 0);
        arm        = (i == arm_at);
        sb.push_back(e);
        if (sb.size() > DEPTH) void'(sb.pop_front());
        if (in_post) begin
          rem--;
          post_done++;
          if (rem == 0) done = 1'b1;
        end else if (e.pc == tpc || trig_forca) begin
          in_post = 1'b1;
          rem     = POST;
          if (rem == 0) done = 1'b1;
        end
        i++;
      end
      @(negedge clk);
    end
    valido     = 1'b0;
    trig_forca = 1'b0;
    arm        = 1'b0;
    if (!done) check("capture_timeout", 0, 1);
    check("post_to_read", estado, 2'd3);
    check("read_valid", rd_valid, 1'b1);
    check("read_count", contagem, sb.size());
  endtask

  // Drains up to 'limit' entries; toggle alternates rd_ready 1/0.
  task automatic readout(input bit toggle, input int limit);
    int n = sb.size();
    int k = 0;
    int acc = 0;
    while (sb.size() > 0 && acc < limit && k < 400) begin
      check("rd_valid", rd_valid, 1'b1);
      check("rd_pc", rd_pc, sb[0].pc);
      check("rd_inst", rd_inst, sb[0].inst);
      check("rd_ula", rd_ula, sb[0].ula);
      check("rd_wb", rd_wb, sb[0].wb);
      check("rd_ciclo", rd_ciclo, sb[0].cyc);
      rd_ready = toggle ? (k % 2 == 0) : 1'b1;
      if (rd_ready) begin
        void'(sb.pop_front());
        acc++;
      end
      k++;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    if (sb.size() == 0) begin
      check("done_state", estado, 2'd0);
      check("done_valid", rd_valid, 1'b0);
      check("done_count", contagem, 0);
      check("rd_cycles", k, toggle ? 2 * n - 1 : n);
    end else begin
      check("partial_count", contagem, sb.size());
    end
  endtask

  initial begin
    #1;
    check("rst_state", estado, 2'd0);
    check("rst_count", contagem, 0);
    check("rst_valid", rd_valid, 1'b0);
    check("rst_pc", rd_pc, 0);
    check("rst_ciclo", rd_ciclo, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    // No wrap: trigger at PC 40, 11 pre + 4 post entries
    do_arm(32'd40);
    capture(32'd40, -1, 0, -1, 1'b0);
    check("nowrap_count", contagem, 15);
    readout(1'b0, 1000);

    // Wrap, with an arm pulse during ARMED that must be ignored
    do_arm(32'd100);
    capture(32'd100, -1, 0, 3, 1'b0);
    check("wrap_count", contagem, 16);
    check("wrap_oldest", rd_pc, 56);
    readout(1'b0, 1000);

    // Qualifier gaps inside POST
    do_arm(32'd40);
    capture(32'd40, 2, 3, -1, 1'b0);
    check("gap_count", contagem, 15);
    readout(1'b0, 1000);

    // Backpressure on a full buffer
    do_arm(32'd100);
    capture(32'd100, -1, 0, -1, 1'b0);
    readout(1'b1, 1000);

    // Forced trigger on the first instruction
    do_arm(32'hFFFF_FFF0);
    capture(32'hFFFF_FFF0, -1, 0, -1, 1'b1);
    check("force_count", contagem, POST + 1);
    readout(1'b0, 1000);

    // Abort mid-readout with rd_ready high
    do_arm(32'd40);
    capture(32'd40, -1, 0, -1, 1'b0);
    readout(1'b0, 3);
    abort    = 1'b1;
    rd_ready = 1'b1;
    @(negedge clk);
    check("abort_state", estado, 2'd0);
    check("abort_valid", rd_valid, 1'b0);
    check("abort_count", contagem, 0);
    abort    = 1'b0;
    rd_ready = 1'b0;
    sb.delete();

    // Reset during POST
    do_arm(32'd8);
    for (int i = 0; i < 4; i++) begin
      drive_instr(i);
      @(negedge clk);
    end
    valido = 1'b0;
    check("pre_rst_post", estado, 2'd2);
    #2 reset = 1'b0;
    #1;
    check("async_rst_state", estado, 2'd0);
    check("async_rst_count", contagem, 0);
    check("async_rst_valid", rd_valid, 1'b0);
    check("async_rst_pc", rd_pc, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive_instr(2);
      trig_forca = 1'b1;
      @(negedge clk);
    end
    valido     = 1'b0;
    trig_forca = 1'b0;
    check("post_rst_idle", estado, 2'd0);
    check("post_rst_count", contagem, 0);

    // Restart after reset needs a fresh arm
    do_arm(32'd40);
    capture(32'd40, -1, 0, -1, 1'b0);
    readout(1'b0, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
